// File: rtl/sysreg_file_pkg.sv
// sysreg_file_pkg: shared widths, register id type and privilege rules for the system register file
package sysreg_file_pkg;
  localparam int GROUP_W = 5;
  localparam int REGNUM_W = 3;
  localparam int PL_W = 2;
  localparam logic [REGNUM_W-1:0] G0_ID = 3'd0;
  localparam logic [REGNUM_W-1:0] G0_CYCLE = 3'd1;
  localparam logic [REGNUM_W-1:0] G0_RETIRED = 3'd2;
  typedef struct packed {
    logic [GROUP_W-1:0] group;
    logic [REGNUM_W-1:0] regnum;
  } sysreg_id_t;
  function automatic logic [PL_W-1:0] min_pl(input logic [GROUP_W-1:0] group);
    return group == '0 ? 2'd0 : group == 5'd1 ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/sysreg_access_check.sv
// sysreg_access_check: combinational legality of one system register access
module sysreg_access_check
  import sysreg_file_pkg::*;
#(
  parameter int NR_GROUPS = 4
) (
  input  logic [GROUP_W-1:0] group,
  input  logic [PL_W-1:0]    plevel,
  input  logic [PL_W-1:0]    cur_pl,
  input  logic               is_write,
  output logic               legal
);
  assign legal = int'(group) < NR_GROUPS && plevel >= min_pl(group) && plevel <= cur_pl &&
                 !(is_write && group == '0);
endmodule

// File: rtl/sysreg_file.sv
// sysreg_file: privileged system register file with read-only id/counter group and writable groups
module sysreg_file
  import sysreg_file_pkg::*;
#(
  parameter int                   REG_WIDTH = 64,
  parameter int                   NR_GROUPS = 4,
  parameter logic [REG_WIDTH-1:0] CORE_ID   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PL_W-1:0]      cur_pl,
  input  logic                 sreg_rd_en,
  input  logic [GROUP_W-1:0]   sreg_rd_group,
  input  logic [REGNUM_W-1:0]  sreg_rd_regnum,
  input  logic [PL_W-1:0]      sreg_rd_plevel,
  output logic                 sreg_rd_valid,
  output logic [REG_WIDTH-1:0] sreg_rd_data,
  output logic                 sreg_rd_fault,
  input  logic                 sreg_wr_en,
  input  logic [GROUP_W-1:0]   sreg_wr_group,
  input  logic [REGNUM_W-1:0]  sreg_wr_regnum,
  input  logic [PL_W-1:0]      sreg_wr_plevel,
  input  logic [REG_WIDTH-1:0] sreg_wr_data,
  output logic                 sreg_wr_fault,
  input  logic                 insn_retire
);
  localparam int GI_W = $clog2(NR_GROUPS);
  sysreg_id_t rd_id, wr_id;
  logic rd_legal, wr_legal;
  logic [REG_WIDTH-1:0] cycle_cnt, retired_cnt, rd_value;
  logic [REG_WIDTH-1:0] regs [NR_GROUPS][8];
  assign rd_id = '{group: sreg_rd_group, regnum: sreg_rd_regnum};
  assign wr_id = '{group: sreg_wr_group, regnum: sreg_wr_regnum};
  sysreg_access_check #(.NR_GROUPS(NR_GROUPS)) u_rd_check (
    .group(rd_id.group), .plevel(sreg_rd_plevel), .cur_pl(cur_pl), .is_write(1'b0), .legal(rd_legal)
  );
  sysreg_access_check #(.NR_GROUPS(NR_GROUPS)) u_wr_check (
    .group(wr_id.group), .plevel(sreg_wr_plevel), .cur_pl(cur_pl), .is_write(1'b1), .legal(wr_legal)
  );
  // Read mux; only meaningful when the access is legal, so indexing never leaves the array
  always_comb begin
    rd_value = '0;
    if (rd_id.group == '0)
      rd_value = rd_id.regnum == G0_ID ? CORE_ID : rd_id.regnum == G0_CYCLE ? cycle_cnt :
                 rd_id.regnum == G0_RETIRED ? retired_cnt : '0;
    else if (rd_legal)
      rd_value = regs[rd_id.group[GI_W-1:0]][rd_id.regnum];
  end
  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      retired_cnt <= retired_cnt + REG_WIDTH'(insn_retire);
    end
  end
  // Writable register storage; group 0 slots are never written and stay zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      regs <= '{default: '0};
    else if (sreg_wr_en && wr_legal)
      regs[wr_id.group[GI_W-1:0]][wr_id.regnum] <= sreg_wr_data;
  end
  // One-cycle read response and write fault pulse; read data holds between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_rd_valid <= 1'b0;
      sreg_rd_data <= '0;
      sreg_rd_fault <= 1'b0;
      sreg_wr_fault <= 1'b0;
    end else begin
      sreg_rd_valid <= sreg_rd_en;
      sreg_wr_fault <= sreg_wr_en && !wr_legal;
      if (sreg_rd_en) begin
        sreg_rd_data <= rd_legal ? rd_value : '0;
        sreg_rd_fault <= !rd_legal;
      end
    end
  end
endmodule

// File: tb/tb_sysreg_file.sv
// tb_sysreg_file: table-driven and directed checks of the system register file
module tb_sysreg_file;
  localparam logic [63:0] CID = 64'hC0DE_0000_0000_0042;
  localparam logic [63:0] ONES = '1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cur_pl = '0;
  logic rd_en = 1'b0, wr_en = 1'b0, insn_retire = 1'b0;
  logic [4:0] rd_group = '0, wr_group = '0;
  logic [2:0] rd_regnum = '0, wr_regnum = '0;
  logic [1:0] rd_plevel = '0, wr_plevel = '0;
  logic [63:0] wr_data = '0;
  logic rd_valid, rd_fault, wr_fault;
  logic [63:0] rd_data;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic rd_en; logic [4:0] rg; logic [2:0] rr; logic [1:0] rp; logic [1:0] cp;
    logic wr_en; logic [4:0] wg; logic [2:0] wn; logic [1:0] wp; logic [63:0] wd;
    logic ev; logic [63:0] ed; logic ef; logic ewf;
  } vec_t;
  vec_t vecs [18];

  sysreg_file #(.REG_WIDTH(64), .NR_GROUPS(4), .CORE_ID(CID)) dut (
    .clk(clk), .rst_n(rst_n), .cur_pl(cur_pl),
    .sreg_rd_en(rd_en), .sreg_rd_group(rd_group), .sreg_rd_regnum(rd_regnum), .sreg_rd_plevel(rd_plevel),
    .sreg_rd_valid(rd_valid), .sreg_rd_data(rd_data), .sreg_rd_fault(rd_fault),
    .sreg_wr_en(wr_en), .sreg_wr_group(wr_group), .sreg_wr_regnum(wr_regnum), .sreg_wr_plevel(wr_plevel),
    .sreg_wr_data(wr_data), .sreg_wr_fault(wr_fault), .insn_retire(insn_retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] g, input logic [2:0] r, input logic [1:0] p);
    rd_en = 1'b1; rd_group = g; rd_regnum = r; rd_plevel = p;
  endtask

  task automatic expect_rd(input string name, input logic [63:0] d, input logic f);
    chk({name, " valid"}, 64'(rd_valid), 64'(1'b1));
    chk({name, " data"}, rd_data, d);
    chk({name, " fault"}, 64'(rd_fault), 64'(f));
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,      1, CID,            0, 0};
    vecs[1]  = '{1, 1, 3, 1, 1, 1, 1, 3, 1, 64'hDEAD,   1, 64'h0,          0, 0};
    vecs[2]  = '{1, 1, 3, 1, 1, 0, 0, 0, 0, 64'h0,      1, 64'hDEAD,       0, 0};
    vecs[3]  = '{0, 0, 0, 0, 3, 1, 2, 0, 1, 64'h1234,   0, 64'hDEAD,       0, 1};
    vecs[4]  = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 64'h0,      0, 64'hDEAD,       0, 0};
    vecs[5]  = '{1, 2, 0, 2, 3, 0, 0, 0, 0, 64'h0,      1, 64'h0,          0, 0};
    vecs[6]  = '{1, 5, 0, 3, 3, 0, 0, 0, 0, 64'h0,      1, 64'h0,          1, 0};
    vecs[7]  = '{1, 0, 2, 0, 2, 1, 2, 7, 2, 64'h55AA,   1, 64'h0,          0, 0};
    vecs[8]  = '{1, 2, 7, 3, 2, 0, 0, 0, 0, 64'h0,      1, 64'h0,          1, 0};
    vecs[9]  = '{1, 2, 7, 2, 2, 0, 0, 0, 0, 64'h0,      1, 64'h55AA,       0, 0};
    vecs[10] = '{1, 0, 3, 3, 3, 1, 0, 0, 3, 64'hBAD,    1, 64'h0,          0, 1};
    vecs[11] = '{1, 1, 0, 0, 3, 1, 3, 7, 3, ONES,       1, 64'h0,          1, 0};
    vecs[12] = '{1, 3, 7, 3, 3, 0, 0, 0, 0, 64'h0,      1, ONES,           0, 0};
    vecs[13] = '{1, 4, 0, 3, 3, 0, 0, 0, 0, 64'h0,      1, 64'h0,          1, 0};
    vecs[14] = '{1, 3, 7, 2, 3, 0, 0, 0, 0, 64'h0,      1, ONES,           0, 0};
    vecs[15] = '{1, 1, 3, 0, 3, 0, 0, 0, 0, 64'h0,      1, 64'h0,          1, 0};
    vecs[16] = '{1, 1, 3, 1, 0, 1, 1, 3, 1, 64'h0,      1, 64'h0,          1, 1};
    vecs[17] = '{1, 1, 3, 1, 1, 0, 0, 0, 0, 64'h0,      1, 64'hDEAD,       0, 0};
    repeat (2) @(negedge clk);
    chk("reset valid", 64'(rd_valid), 64'h0);
    chk("reset data", rd_data, 64'h0);
    chk("reset rd_fault", 64'(rd_fault), 64'h0);
    chk("reset wr_fault", 64'(wr_fault), 64'h0);
    rst_n = 1'b1;
    rd(0, 1, 0);
    step();
    expect_rd("cycle first edge", 64'h0, 1'b0);
    step();
    expect_rd("cycle second edge", 64'h1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      rd_en = vecs[i].rd_en; rd_group = vecs[i].rg; rd_regnum = vecs[i].rr; rd_plevel = vecs[i].rp;
      cur_pl = vecs[i].cp;
      wr_en = vecs[i].wr_en; wr_group = vecs[i].wg; wr_regnum = vecs[i].wn; wr_plevel = vecs[i].wp;
      wr_data = vecs[i].wd;
      step();
      chk($sformatf("vec%0d valid", i), 64'(rd_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d data", i), rd_data, vecs[i].ed);
      chk($sformatf("vec%0d rd_fault", i), 64'(rd_fault), 64'(vecs[i].ef));
      chk($sformatf("vec%0d wr_fault", i), 64'(wr_fault), 64'(vecs[i].ewf));
    end
    wr_en = 1'b0;
    cur_pl = 2'd3;
    force dut.cycle_cnt = ONES;
    #1 release dut.cycle_cnt;
    rd(0, 1, 3);
    step();
    expect_rd("cycle at all-ones", ONES, 1'b0);
    step();
    expect_rd("cycle wrapped", 64'h0, 1'b0);
    rd(0, 2, 3);
    step();
    expect_rd("retired before", 64'h0, 1'b0);
    rd_en = 1'b0;
    insn_retire = 1'b1;
    repeat (3) step();
    insn_retire = 1'b0;
    rd(0, 2, 3);
    step();
    expect_rd("retired after 3", 64'h3, 1'b0);
    rd(5, 0, 3);
    step();
    expect_rd("b2b 0 g5", 64'h0, 1'b1);
    rd(1, 3, 1);
    step();
    expect_rd("b2b 1 g1r3", 64'hDEAD, 1'b0);
    rd(2, 7, 2);
    step();
    expect_rd("b2b 2 g2r7", 64'h55AA, 1'b0);
    rd(3, 7, 3);
    step();
    expect_rd("b2b 3 g3r7", ONES, 1'b0);
    rd(1, 3, 1);
    rst_n = 1'b0;
    #1;
    chk("async clear data", rd_data, 64'h0);
    chk("async clear valid", 64'(rd_valid), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    rst_n = 1'b1;
    step();
    chk("dropped read valid", 64'(rd_valid), 64'h0);
    step();
    chk("dropped read valid later", 64'(rd_valid), 64'h0);
    rd(1, 3, 1);
    step();
    expect_rd("g1r3 after reset", 64'h0, 1'b0);
    rd(3, 7, 3);
    step();
    expect_rd("g3r7 after reset", 64'h0, 1'b0);
    rd_en = 1'b0;
    step();
    chk("idle valid", 64'(rd_valid), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
